tt_um_lane_swizzler: RTL and testbench

- Registered, parametrised lane-permutation engine for a TinyTapeout tile.
- Captures an 8-bit word on a load strobe and presents one of four transforms on `uo_out`: pass, half-swap, lane-reverse, or continuous lane rotation ("spin").
- Status is reported on the upper bidirectional pins.
- Successor to the tile's fixed nibble-swap datapath; half-swap mode reproduces that function.

---
 rtl/lane_swizzler_pkg.sv | 27 ++
 rtl/lane_permute.sv | 34 +++
 rtl/tt_um_lane_swizzler.sv | 111 +++++++++++
 tb/tb_tt_um_lane_swizzler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lane_swizzler_pkg.sv
// Shared encodings for the lane swizzler tile: mode codes, FSM states and uio pin map.
package lane_swizzler_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_SWAP = 2'b01,
    MODE_REV  = 2'b10,
    MODE_SPIN = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READY = 2'b01,
    SPIN  = 2'b10
  } state_e;

  localparam int UIO_LOAD    = 0;
  localparam int UIO_MODE_LO = 1;
  localparam int UIO_HOLD    = 3;
  localparam int UIO_VALID   = 4;
  localparam int UIO_WRAP    = 5;
  localparam int UIO_BUSY    = 6;
  localparam int UIO_PARITY  = 7;

  localparam logic [7:0] UIO_OE_VALUE = 8'hF0;

endpackage

// File: rtl/lane_permute.sv
// Combinational lane permutation: pass, half-swap or lane-reverse of one word.
module lane_permute
  import lane_swizzler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANE  = 2
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_word
);

  localparam int NLANES = WIDTH / LANE;

  logic [WIDTH-1:0] w_rev;

  // Lane order reversed, bits inside each lane keep their order.
  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_rev
      assign w_rev[gi*LANE +: LANE] = i_word[(NLANES-1-gi)*LANE +: LANE];
    end
  endgenerate

  always_comb begin
    o_word = i_word;
    case (mode_e'(i_mode))
      MODE_SWAP: o_word = {i_word[WIDTH/2-1:0], i_word[WIDTH-1:WIDTH/2]};
      MODE_REV:  o_word = w_rev;
      default:   o_word = i_word;
    endcase
  end

endmodule

// File: rtl/tt_um_lane_swizzler.sv
// Registered lane-permutation tile with spin mode and status pins.
// Optional parity output enabled by defining SWIZZLE_PARITY_EN.
module tt_um_lane_swizzler
  import lane_swizzler_pkg::*;
#(
  parameter int LANE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NLANES = 8 / LANE;
  localparam int CW     = (NLANES > 1) ? $clog2(NLANES) : 1;

  logic [7:0]    r_data;
  logic [7:0]    r_out;
  logic [CW-1:0] r_cnt;
  state_e        r_state;
  logic          r_wrap;
  logic          r_wrap_pend;
  logic          w_par;

  logic          w_load;
  logic [1:0]    w_mode;
  logic          w_hold;
  logic          w_spin_req;
  logic          w_last;
  logic [7:0]    w_perm;
  logic [7:0]    w_rot;
  logic          w_unused;

  assign w_load     = uio_in[UIO_LOAD];
  assign w_mode     = uio_in[UIO_MODE_LO +: 2];
  assign w_hold     = uio_in[UIO_HOLD];
  assign w_spin_req = (mode_e'(w_mode) == MODE_SPIN) && !w_hold;
  assign w_last     = (r_cnt == CW'(NLANES - 1));
  assign w_rot      = {r_data[7-LANE:0], r_data[7:8-LANE]};
  assign w_unused   = &{1'b0, uio_in[7:4]};

  lane_permute #(
    .WIDTH (8),
    .LANE  (LANE)
  ) u_permute (
    .i_word (r_data),
    .i_mode (w_mode),
    .o_word (w_perm)
  );

  // The wrapping rotation lands in r_data one cycle before it reaches r_out,
  // so the wrap flag is staged through r_wrap_pend to line up with r_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= 8'h00;
      r_out       <= 8'h00;
      r_cnt       <= '0;
      r_state     <= IDLE;
      r_wrap      <= 1'b0;
      r_wrap_pend <= 1'b0;
    end else if (ena) begin
      r_out       <= w_perm;
      r_wrap      <= r_wrap_pend;
      r_wrap_pend <= 1'b0;
      if (w_load) begin
        r_data  <= ui_in;
        r_cnt   <= '0;
        r_state <= READY;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          READY: begin
            if (w_spin_req) r_state <= SPIN;
          end
          SPIN: begin
            if (!w_spin_req) begin
              r_state <= READY;
            end else begin
              r_data      <= w_rot;
              r_cnt       <= w_last ? '0 : r_cnt + CW'(1);
              r_wrap_pend <= w_last;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

`ifdef SWIZZLE_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_par <= 1'b0;
    else if (ena) r_par <= ^r_data;
  end
  assign w_par = r_par;
`else
  assign w_par = 1'b0;
`endif

  assign uo_out  = r_out;
  assign uio_out = {w_par, (r_state == SPIN), r_wrap, (r_state != IDLE), 4'b0000};
  assign uio_oe  = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_lane_swizzler.sv
// Directed self-checking bench for tt_um_lane_swizzler (LANE=2).
module tb_tt_um_lane_swizzler;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

`ifdef SWIZZLE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  tt_um_lane_swizzler #(.LANE(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%02h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // uio_out status bits excluding parity: {busy, wrap, valid} in [6:4]
  function automatic logic [7:0] stat(input bit busy, input bit wrap, input bit valid);
    return {1'b0, busy, wrap, valid, 4'b0000};
  endfunction

  logic [7:0] spin_exp [5] = '{8'h81, 8'h06, 8'h18, 8'h60, 8'h81};
  logic [7:0] load_exp [5] = '{8'h3C, 8'hF0, 8'hC3, 8'h0F, 8'h3C};

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      ui_in  = 8'h5A ^ 8'(i * 37);
      uio_in = 8'(i) | 8'h01;
      step();
    end
    check("rst_uo",      uo_out,  8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe",  uio_oe,  8'hF0);
    uio_in = 8'h00;
    rst_n  = 1'b1;
    step();
    check("idle_status", uio_out & 8'h70, stat(0, 0, 0));

    // SWAP: load 0xA5 with mode 01
    ui_in  = 8'hA5;
    uio_in = 8'h03;
    step();
    check("swap_latency", uo_out, 8'h00);
    uio_in = 8'h02;
    step();
    check("swap_out",    uo_out,          8'h5A);
    check("swap_status", uio_out & 8'h70, stat(0, 0, 1));

    // REVERSE: load 0xB4 with mode 10
    ui_in  = 8'hB4;
    uio_in = 8'h05;
    step();
    uio_in = 8'h04;
    step();
    check("rev_out", uo_out, 8'h1E);

    // Mode change on held data
    uio_in = 8'h00;
    step();
    check("mode_pass", uo_out, 8'hB4);
    uio_in = 8'h02;
    step();
    check("mode_swap", uo_out, 8'h4B);

    // SPIN: load 0x81, then mode 11
    ui_in  = 8'h81;
    uio_in = 8'h01;
    step();
    uio_in = 8'h06;
    step();
    check("spin_enter_out",  uo_out,          8'h81);
    check("spin_enter_stat", uio_out & 8'h70, stat(1, 0, 1));
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("spin_seq%0d", i),  uo_out,          spin_exp[i]);
      check($sformatf("spin_stat%0d", i), uio_out & 8'h70, stat(1, (i == 4), 1));
    end
    step();
    check("spin_wrap_clear", uio_out & 8'h70, stat(1, 0, 1));

    // Load 0x3C while spinning; counter restarts from 0
    ui_in  = 8'h3C;
    uio_in = 8'h07;
    step();
    uio_in = 8'h06;
    step();
    check("load_spin_out", uo_out, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("reload_seq%0d", i),  uo_out,          load_exp[i]);
      check($sformatf("reload_stat%0d", i), uio_out & 8'h70, stat(1, (i == 4), 1));
    end

    // hold=1 stops rotation; data last rotated to 0xF0
    uio_in = 8'h0E;
    step();
    check("hold_first", uo_out, 8'hF0);
    step();
    step();
    check("hold_frozen", uo_out,          8'hF0);
    check("hold_status", uio_out & 8'h70, stat(0, 0, 1));

    // Resume spin, then freeze with ena=0
    uio_in = 8'h06;
    step();
    check("resume_enter", uo_out, 8'hF0);
    step();
    check("resume_rot0", uo_out, 8'hF0);
    step();
    check("resume_rot1", uo_out, 8'hC3);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("ena_frozen_out",  uo_out,          8'hC3);
    check("ena_frozen_stat", uio_out & 8'h70, stat(1, 0, 1));
    ena = 1'b1;
    step();
    check("ena_resume_out", uo_out, 8'h0F);
    step();
    check("ena_resume_wrap_out",  uo_out,          8'h3C);
    check("ena_resume_wrap_stat", uio_out & 8'h70, stat(1, 1, 1));

    // Asynchronous reset mid-spin
    #2;
    rst_n = 1'b0;
    #1;
    check("midspin_rst_uo",  uo_out,  8'h00);
    check("midspin_rst_uio", uio_out, 8'h00);
    step();
    rst_n  = 1'b1;
    uio_in = 8'h00;
    step();

    // Parity
    ui_in  = 8'h07;
    uio_in = 8'h01;
    step();
    uio_in = 8'h00;
    step();
    check("par07_out", uo_out, 8'h07);
    check("par07_bit", {7'b0, uio_out[7]}, {7'b0, PAR_EN});
    ui_in  = 8'h81;
    uio_in = 8'h01;
    step();
    uio_in = 8'h00;
    step();
    check("par81_out", uo_out, 8'h81);
    check("par81_bit", {7'b0, uio_out[7]}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
